// File: rtl/smallcpu_pkg.sv
// Shared types and constants for the small CPU memory subsystem.
// Holds the arbiter FSM encoding, requester IDs and default datapath width.
package smallcpu_pkg;

  localparam int unsigned N_DEFAULT = 16;

  // Requester IDs double as the bit index into the packed {d_req, f_req} vector.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection.
// A lone requester always wins; on contention the one not granted last time wins.
module rr_pick2
  import smallcpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = REQ_FETCH;
    if (req[REQ_FETCH] && req[REQ_DATA]) begin
      winner = ~last_grant;
    end else if (req[REQ_DATA]) begin
      winner = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with registered read data.
// One access per two cycles: arbitrate in IDLE/RESP, issue in ACCESS, return in RESP.
module mem_arbiter
  import smallcpu_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         f_req,
  input  logic [N-1:0] f_addr,
  output logic         f_gnt,
  output logic         f_rvalid,
  input  logic         d_req,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  input  logic         d_we,
  output logic         d_gnt,
  output logic         d_rvalid,
  output logic [N-1:0] rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_din,
  output logic         mem_we,
  input  logic [N-1:0] mem_dout
);

  arb_state_e   state_q, state_d;
  logic         last_grant_q;
  logic         win_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic         we_q;

  logic         pick_valid;
  logic         pick_winner;
  logic         latch;

  rr_pick2 u_pick (
    .req        ({d_req, f_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // RESP overlaps the next arbitration, so both IDLE and RESP may latch.
  assign latch = (state_q != StAccess) && pick_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StResp: state_d = pick_valid ? StAccess : StIdle;
      StAccess:       state_d = StResp;
      default:        state_d = StIdle;
    endcase
  end

  // Last grant resets to data so fetch wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_DATA;
      win_q        <= REQ_FETCH;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else if (latch) begin
      last_grant_q <= pick_winner;
      win_q        <= pick_winner;
      addr_q       <= (pick_winner == REQ_DATA) ? d_addr : f_addr;
      wdata_q      <= d_wdata;
      we_q         <= (pick_winner == REQ_DATA) && d_we;
    end
  end

  // Strobes decode from the registered state, so reset clears them asynchronously.
  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    f_rvalid = 1'b0;
    d_rvalid = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      StAccess: begin
        f_gnt  = (win_q == REQ_FETCH);
        d_gnt  = (win_q == REQ_DATA);
        mem_we = we_q;
      end
      StResp: begin
        f_rvalid = (win_q == REQ_FETCH);
        d_rvalid = (win_q == REQ_DATA);
      end
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign rdata    = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;

  localparam int unsigned N = 16;

  logic         clk;
  logic         rst;
  logic         f_req;
  logic [N-1:0] f_addr;
  logic         f_gnt;
  logic         f_rvalid;
  logic         d_req;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic         d_we;
  logic         d_gnt;
  logic         d_rvalid;
  logic [N-1:0] rdata;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_din;
  logic         mem_we;
  logic [N-1:0] mem_dout;

  logic [N-1:0] mem [0:65535];

  int unsigned n_checks;
  int unsigned n_fail;

  mem_arbiter #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_we     (d_we),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, " f_gnt"}, 32'(f_gnt), 32'd0);
    check_eq({tag, " d_gnt"}, 32'(d_gnt), 32'd0);
    check_eq({tag, " f_rvalid"}, 32'(f_rvalid), 32'd0);
    check_eq({tag, " d_rvalid"}, 32'(d_rvalid), 32'd0);
    check_eq({tag, " mem_we"}, 32'(mem_we), 32'd0);
  endtask

  // F,D round-robin under constant contention: gnt every 2nd cycle.
  logic [7:0] exp_fg = 8'b0001_0001;
  logic [7:0] exp_dg = 8'b0100_0100;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    mem[16'h0005] = 16'h8123;
    mem[16'h0010] = 16'h0000;
    mem[16'h0020] = 16'h2222;
    mem[16'hFFFF] = 16'h5A5A;

    step();
    step();
    check_quiet("reset");
    check_eq("reset mem_addr", 32'(mem_addr), 32'h0);
    rst = 1'b0;
    step();
    check_quiet("idle");

    // Single fetch of 0x0005
    f_req = 1'b1; f_addr = 16'h0005;
    step();
    check_eq("fetch f_gnt", 32'(f_gnt), 32'd1);
    check_eq("fetch d_gnt", 32'(d_gnt), 32'd0);
    check_eq("fetch mem_addr", 32'(mem_addr), 32'h0005);
    check_eq("fetch mem_we", 32'(mem_we), 32'd0);
    f_req = 1'b0;
    step();
    check_eq("fetch f_rvalid", 32'(f_rvalid), 32'd1);
    check_eq("fetch rdata", 32'(rdata), 32'h8123);
    check_eq("fetch d_rvalid", 32'(d_rvalid), 32'd0);
    check_eq("fetch f_gnt resp", 32'(f_gnt), 32'd0);
    step();
    check_quiet("fetch done");

    // Data write 0x0010 <- 0xBEEF, then fetch it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
    step();
    check_eq("wr d_gnt", 32'(d_gnt), 32'd1);
    check_eq("wr mem_we", 32'(mem_we), 32'd1);
    check_eq("wr mem_addr", 32'(mem_addr), 32'h0010);
    check_eq("wr mem_din", 32'(mem_din), 32'hBEEF);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check_eq("wr d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("wr mem_we resp", 32'(mem_we), 32'd0);
    check_eq("wr f_rvalid", 32'(f_rvalid), 32'd0);
    f_req = 1'b1; f_addr = 16'h0010;
    step();
    check_eq("rb f_gnt", 32'(f_gnt), 32'd1);
    check_eq("rb mem_we", 32'(mem_we), 32'd0);
    f_req = 1'b0;
    step();
    check_eq("rb f_rvalid", 32'(f_rvalid), 32'd1);
    check_eq("rb rdata", 32'(rdata), 32'hBEEF);
    step();

    // Reset, then 8 cycles of constant contention
    rst = 1'b1;
    step();
    check_quiet("rst2");
    rst = 1'b0;
    f_req = 1'b1; f_addr = 16'h0005;
    d_req = 1'b1; d_addr = 16'h0010; d_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("rr f_gnt c%0d", i), 32'(f_gnt), 32'(exp_fg[i]));
      check_eq($sformatf("rr d_gnt c%0d", i), 32'(d_gnt), 32'(exp_dg[i]));
      if (i == 1) check_eq("rr f rdata", 32'(rdata), 32'h8123);
      if (i == 3) check_eq("rr d rdata", 32'(rdata), 32'hBEEF);
    end
    f_req = 1'b0; d_req = 1'b0;
    step();
    step();
    check_quiet("rr done");

    // Reset during the ACCESS cycle of a write to 0x0020
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1111;
    step();
    check_eq("abort d_gnt", 32'(d_gnt), 32'd1);
    check_eq("abort mem_we pre", 32'(mem_we), 32'd1);
    rst = 1'b1;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    check_eq("abort mem_we async", 32'(mem_we), 32'd0);
    check_eq("abort d_gnt async", 32'(d_gnt), 32'd0);
    step();
    check_quiet("abort held");
    check_eq("abort mem unchanged", 32'(mem[16'h0020]), 32'h2222);
    rst = 1'b0;
    step();
    check_quiet("abort after");
    f_req = 1'b1; f_addr = 16'h0005;
    d_req = 1'b1; d_addr = 16'h0020;
    step();
    check_eq("post f_gnt", 32'(f_gnt), 32'd1);
    check_eq("post d_gnt", 32'(d_gnt), 32'd0);
    f_req = 1'b0;
    step();
    check_eq("post f_rvalid", 32'(f_rvalid), 32'd1);
    step();
    check_eq("post d_gnt2", 32'(d_gnt), 32'd1);
    d_req = 1'b0;
    step();
    check_eq("post d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("post d rdata", 32'(rdata), 32'h2222);
    step();

    // Read of 0xFFFF, then a fetch that drops req in its ACCESS cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFFF;
    step();
    check_eq("top d_gnt", 32'(d_gnt), 32'd1);
    check_eq("top mem_addr", 32'(mem_addr), 32'hFFFF);
    d_req = 1'b0;
    f_req = 1'b1; f_addr = 16'h0010;
    step();
    check_eq("top d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("top rdata", 32'(rdata), 32'h5A5A);
    step();
    check_eq("drop f_gnt", 32'(f_gnt), 32'd1);
    f_req = 1'b0;
    step();
    check_eq("drop f_rvalid", 32'(f_rvalid), 32'd1);
    check_eq("drop rdata", 32'(rdata), 32'hBEEF);
    step();
    check_quiet("final idle");
    check_eq("hold mem_addr", 32'(mem_addr), 32'h0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
